// File: rtl/dca_matrix_lsu_wdata_serializer.sv
// Splits one packed LSU store row into an AXI W burst with computed WSTRB/WLAST.
// Optional DCA_LSU_WDATA_SKID_EN adds a one-row buffer for zero-bubble back-to-back bursts.
module dca_matrix_lsu_wdata_serializer #(
    parameter int MATRIX_NUM_COL = 4,
    parameter int BW_ELEMENT_MAX = 32,
    parameter int BW_AXI_DATA    = 32,
    parameter int BW_TXN_INFO    = 8,
    parameter int BW_NUM_COL_M1  = 2
) (
    input  logic                                     clk,
    input  logic                                     rstnn,
    input  logic                                     row_valid,
    output logic                                     row_ready,
    input  logic [MATRIX_NUM_COL*BW_ELEMENT_MAX-1:0] row_data,
    input  logic [2:0]                               row_lsa_p3,
    input  logic [BW_NUM_COL_M1-1:0]                 row_num_col_m1,
    input  logic [BW_TXN_INFO-1:0]                   row_txn_info,
    output logic                                     wvalid,
    input  logic                                     wready,
    output logic [BW_AXI_DATA-1:0]                   wdata,
    output logic [BW_AXI_DATA/8-1:0]                 wstrb,
    output logic                                     wlast,
    output logic [BW_TXN_INFO-1:0]                   wtxn_info
);
    localparam int ROW_W = MATRIX_NUM_COL * BW_ELEMENT_MAX;
    localparam int BPB   = BW_AXI_DATA / 8;
    localparam int NB    = ROW_W / BW_AXI_DATA;
    localparam int BT_W  = (NB > 1) ? $clog2(NB) : 1;
    localparam int VB_W  = $clog2(MATRIX_NUM_COL * 32 + 1) + 1;

    typedef enum logic {IDLE, SEND} state_t;

    typedef struct packed {
        logic [ROW_W-1:0]       data;
        logic [BT_W-1:0]        last_beat;
        logic [BPB-1:0]         last_strb;
        logic [BW_TXN_INFO-1:0] txn;
    } row_t;

    state_t state_q, state_d;
    row_t   in_row, cur_q;
    logic [BT_W-1:0] beat_q;
    logic [2:0]      lsa;
    logic [VB_W-1:0] cols, valid_bits, nbytes, nbeats, rem;
    logic accept, beat_hs, beat_done, load;
    logic [NB-1:0][BW_AXI_DATA-1:0] beat_view;

`ifdef DCA_LSU_WDATA_SKID_EN
    row_t buf_q;
    logic buf_full_q, load_from_buf, buf_push;
    assign row_ready = rstnn && !buf_full_q;
`else
    assign row_ready = rstnn && (state_q == IDLE);
`endif

    // Burst geometry is derived once at acceptance so the beat path only compares counters.
    always_comb begin
        lsa        = (row_lsa_p3 > 3'd5) ? 3'd5 : row_lsa_p3;
        cols       = VB_W'(row_num_col_m1) + VB_W'(1);
        valid_bits = cols << lsa;
        nbytes     = (valid_bits + VB_W'(7)) >> 3;
        nbeats     = (nbytes + VB_W'(BPB - 1)) / VB_W'(BPB);
        rem        = nbytes % VB_W'(BPB);
        in_row.data      = row_data & ~({ROW_W{1'b1}} << valid_bits);
        in_row.last_beat = BT_W'(nbeats - VB_W'(1));
        in_row.txn       = row_txn_info;
        for (int i = 0; i < BPB; i++)
            in_row.last_strb[i] = (rem == '0) || (VB_W'(i) < rem);
    end

    assign accept    = row_valid && row_ready;
    assign beat_hs   = wvalid && wready;
    assign beat_done = beat_hs && wlast;

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
`ifdef DCA_LSU_WDATA_SKID_EN
        load_from_buf = 1'b0;
        buf_push      = 1'b0;
`endif
        case (state_q)
            IDLE: if (accept) begin
                load    = 1'b1;
                state_d = SEND;
            end
            SEND: begin
                if (beat_done) begin
`ifdef DCA_LSU_WDATA_SKID_EN
                    if (buf_full_q) begin
                        load          = 1'b1;
                        load_from_buf = 1'b1;
                    end else if (accept) begin
                        load = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
`else
                    state_d = IDLE;
`endif
                end
`ifdef DCA_LSU_WDATA_SKID_EN
                else if (accept) begin
                    buf_push = 1'b1;
                end
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstnn) begin
            state_q <= IDLE;
            beat_q  <= '0;
            cur_q   <= '0;
        end else begin
            state_q <= state_d;
            if (load) begin
`ifdef DCA_LSU_WDATA_SKID_EN
                cur_q <= load_from_buf ? buf_q : in_row;
`else
                cur_q <= in_row;
`endif
                beat_q <= '0;
            end else if (beat_done) begin
                beat_q <= '0;
            end else if (beat_hs) begin
                beat_q <= beat_q + BT_W'(1);
            end
        end
    end

`ifdef DCA_LSU_WDATA_SKID_EN
    always_ff @(posedge clk) begin
        if (!rstnn) begin
            buf_q      <= '0;
            buf_full_q <= 1'b0;
        end else if (buf_push) begin
            buf_q      <= in_row;
            buf_full_q <= 1'b1;
        end else if (load_from_buf) begin
            buf_full_q <= 1'b0;
        end
    end
`endif

    // Outputs are forced to zero outside a burst so reset and idle look identical downstream.
    assign beat_view = cur_q.data;
    assign wvalid    = (state_q == SEND);
    assign wlast     = wvalid && (beat_q == cur_q.last_beat);
    assign wdata     = wvalid ? beat_view[beat_q] : '0;
    assign wstrb     = !wvalid ? '0 : (wlast ? cur_q.last_strb : {BPB{1'b1}});
    assign wtxn_info = wvalid ? cur_q.txn : '0;

endmodule

// File: tb/tb_dca_matrix_lsu_wdata_serializer.sv
// Directed bench for the W-data serializer with a queue-based burst model and literal pins.
module tb_dca_matrix_lsu_wdata_serializer;
    logic         clk = 1'b0;
    logic         rstnn;
    logic         row_valid;
    logic         row_ready;
    logic [127:0] row_data;
    logic [2:0]   row_lsa_p3;
    logic [1:0]   row_num_col_m1;
    logic [7:0]   row_txn_info;
    logic         wvalid;
    logic         wready;
    logic [31:0]  wdata;
    logic [3:0]   wstrb;
    logic         wlast;
    logic [7:0]   wtxn_info;

    dca_matrix_lsu_wdata_serializer dut (
        .clk(clk), .rstnn(rstnn),
        .row_valid(row_valid), .row_ready(row_ready), .row_data(row_data),
        .row_lsa_p3(row_lsa_p3), .row_num_col_m1(row_num_col_m1), .row_txn_info(row_txn_info),
        .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb),
        .wlast(wlast), .wtxn_info(wtxn_info)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] d;
        logic [3:0]  s;
        logic        l;
        logic [7:0]  t;
    } beat_t;

    beat_t       exp_q[$];
    logic [31:0] obs_d[$];
    logic [3:0]  obs_s[$];
    logic        obs_l[$];
    logic        trace[$];
    logic        rec = 1'b0;
    int          n_cmp = 0;
    int          n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Burst expected from the byte/beat arithmetic on the raw row fields.
    task automatic model_push(input logic [127:0] data, input int lsa_in, input int ncm1,
                              input logic [7:0] txn);
        int lsa, vb, nbytes, nbeats, r;
        logic [127:0] m;
        beat_t b;
        lsa    = (lsa_in > 5) ? 5 : lsa_in;
        vb     = (ncm1 + 1) * (1 << lsa);
        nbytes = (vb + 7) / 8;
        if (nbytes < 1) nbytes = 1;
        nbeats = (nbytes + 3) / 4;
        r      = nbytes % 4;
        m      = data;
        for (int i = 0; i < 128; i++) if (i >= vb) m[i] = 1'b0;
        for (int k = 0; k < nbeats; k++) begin
            b.d = m[k*32 +: 32];
            b.l = (k == nbeats - 1);
            b.s = (b.l && r != 0) ? 4'((1 << r) - 1) : 4'hF;
            b.t = txn;
            exp_q.push_back(b);
        end
    endtask

    always @(negedge clk) begin
        beat_t e;
        if (rec) trace.push_back(wvalid);
        if (wvalid && wready) begin
            obs_d.push_back(wdata);
            obs_s.push_back(wstrb);
            obs_l.push_back(wlast);
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_beat: got wdata %0h, expected no beat", wdata);
            end else begin
                e = exp_q.pop_front();
                chk("beat", {23'd0, wdata, wstrb, wlast, wtxn_info}, {23'd0, e.d, e.s, e.l, e.t});
            end
        end
        if (!rstnn) exp_q.delete();
        else if (row_valid && row_ready)
            model_push(row_data, int'(row_lsa_p3), int'(row_num_col_m1), row_txn_info);
    end

    task automatic send_row(input logic [127:0] d, input logic [2:0] l, input logic [1:0] n,
                            input logic [7:0] t);
        logic acc;
        row_valid = 1'b1; row_data = d; row_lsa_p3 = l; row_num_col_m1 = n; row_txn_info = t;
        acc = 1'b0;
        for (int c = 0; c < 50 && !acc; c++) begin
            @(negedge clk);
            acc = row_ready;
            @(posedge clk);
        end
        #1 row_valid = 1'b0;
        if (!acc) chk("row_accept_timeout", {63'd0, acc}, 64'd1);
    endtask

    task automatic wait_idle();
        int c;
        c = 0;
        while ((exp_q.size() != 0 || wvalid) && c < 200) begin
            @(posedge clk); #1;
            c++;
        end
        if (c >= 200) chk("idle_timeout", 64'(exp_q.size()), 64'd0);
        @(posedge clk); #1;
    endtask

    task automatic clear_obs();
        obs_d.delete(); obs_s.delete(); obs_l.delete();
    endtask

    localparam logic [127:0] ROW_A = 128'h44444444_33333333_22222222_11111111;

    initial begin
        int first1, last1, ones, gap;
        rstnn = 1'b0; row_valid = 1'b0; row_data = '0; row_lsa_p3 = '0;
        row_num_col_m1 = '0; row_txn_info = '0; wready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_wvalid", {63'd0, wvalid}, 64'd0);
        chk("rst_row_ready", {63'd0, row_ready}, 64'd0);
        chk("rst_wdata", {32'd0, wdata}, 64'd0);
        chk("rst_wstrb", {60'd0, wstrb}, 64'd0);
        chk("rst_wlast", {63'd0, wlast}, 64'd0);
        chk("rst_wtxn", {56'd0, wtxn_info}, 64'd0);
        rstnn = 1'b1;
        #1 chk("rel_row_ready", {63'd0, row_ready}, 64'd1);
        @(posedge clk); #1;

        // full-width row
        clear_obs();
        send_row(ROW_A, 3'd5, 2'd3, 8'hA1);
        chk("t1_latency_wvalid", {63'd0, wvalid}, 64'd1);
        wait_idle();
        chk("t1_nbeats", 64'(obs_d.size()), 64'd4);
        chk("t1_d0", {32'd0, obs_d[0]}, 64'h11111111);
        chk("t1_d1", {32'd0, obs_d[1]}, 64'h22222222);
        chk("t1_d2", {32'd0, obs_d[2]}, 64'h33333333);
        chk("t1_d3", {32'd0, obs_d[3]}, 64'h44444444);
        chk("t1_strb", {48'd0, obs_s[0], obs_s[1], obs_s[2], obs_s[3]}, 64'hFFFF);
        chk("t1_last", {60'd0, obs_l[0], obs_l[1], obs_l[2], obs_l[3]}, 64'b0001);

        // partial last beat
        clear_obs();
        send_row({128{1'b1}}, 3'd3, 2'd2, 8'hB2);
        wait_idle();
        chk("t2_nbeats", 64'(obs_d.size()), 64'd1);
        chk("t2_beat", {27'd0, obs_d[0], obs_s[0], obs_l[0]}, {27'd0, 32'h00FFFFFF, 4'h7, 1'b1});

        // sub-byte element
        clear_obs();
        send_row({128{1'b1}}, 3'd0, 2'd0, 8'hC3);
        wait_idle();
        chk("t3_nbeats", 64'(obs_d.size()), 64'd1);
        chk("t3_beat", {27'd0, obs_d[0], obs_s[0], obs_l[0]}, {27'd0, 32'h00000001, 4'h1, 1'b1});

        // lsa above 5 clamps to 32-bit elements: 2 cols -> 2 full beats
        clear_obs();
        send_row(ROW_A, 3'd7, 2'd1, 8'hC4);
        wait_idle();
        chk("t3b_nbeats", 64'(obs_d.size()), 64'd2);

        // backpressure on beat 1
        wready = 1'b0;
        send_row(ROW_A, 3'd4, 2'd3, 8'hD4);
        for (int i = 0; i < 3; i++) begin
            chk("t4_hold", {26'd0, wvalid, wdata, wstrb, wlast},
                {26'd0, 1'b1, 32'h11111111, 4'hF, 1'b0});
            if (i < 2) begin @(posedge clk); #1; end
        end
        wready = 1'b1;
        @(posedge clk); #1;
        chk("t4_beat2", {26'd0, wvalid, wdata, wstrb, wlast},
            {26'd0, 1'b1, 32'h22222222, 4'hF, 1'b1});
        wait_idle();

        // reset mid-burst during beat 2 of 4
        send_row(ROW_A, 3'd5, 2'd3, 8'hE5);
        @(posedge clk); #1;
        rstnn = 1'b0;
        @(posedge clk); #1;
        chk("t5_rst_wvalid", {63'd0, wvalid}, 64'd0);
        chk("t5_rst_row_ready", {63'd0, row_ready}, 64'd0);
        rstnn = 1'b1;
        #1 chk("t5_rel_row_ready", {63'd0, row_ready}, 64'd1);
        clear_obs();
        send_row({96'hAAAAAAAA_BBBBBBBB_CCCCCCCC, 32'h12345678}, 3'd5, 2'd0, 8'hE6);
        wait_idle();
        chk("t5_nbeats", 64'(obs_d.size()), 64'd1);
        chk("t5_new_beat0", {32'd0, obs_d[0]}, 64'h12345678);

        // back-to-back two 2-beat rows
        trace.delete();
        rec = 1'b1;
        send_row(ROW_A, 3'd4, 2'd3, 8'hF1);
        send_row(~ROW_A, 3'd4, 2'd3, 8'hF2);
        wait_idle();
        rec = 1'b0;
        first1 = -1; last1 = -1; ones = 0;
        foreach (trace[i]) if (trace[i]) begin
            if (first1 < 0) first1 = i;
            last1 = i;
            ones++;
        end
        gap = (first1 < 0) ? -1 : (last1 - first1 + 1 - ones);
        chk("t6_beats", 64'(ones), 64'd4);
`ifdef DCA_LSU_WDATA_SKID_EN
        chk("t6_gap", 64'(gap), 64'd0);
`else
        chk("t6_gap", 64'(gap), 64'd1);
`endif
        chk("end_queue_empty", 64'(exp_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
